ps2_host_tx: RTL

- PS/2 host-to-device transmitter. Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard, using the PS/2 host-request protocol on open-drain clock/data lines.
- Complements the existing PS/2 receive path. While a frame is in flight, `rx_hold` tells the receiver to discard device clocks.
- Sits beside the keyboard receiver in the keyboard/VGA application. Shares the two PS/2 pins through external tristate buffers.

---
 rtl/ps2_host_tx.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_host_tx
// Brief    : PS/2 host-to-device command transmitter. Holds the PS/2 clock
//            low to request-to-send, presents an 11-bit frame
//            (start, 8 data LSB first, odd parity, stop) one bit per device
//            falling edge, checks the device ack, and reports timeouts.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
    parameter int INHIBIT_CYC   = 6000,
    parameter int START_TIMEOUT = 750000,
    parameter int XFER_TIMEOUT  = 100000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       wr,
    input  logic [7:0] din,
    output logic       busy,
    output logic       done,
    output logic [1:0] err,
    output logic       rx_hold,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    // FSM encoding
    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_INHIBIT  = 3'd1;
    localparam logic [2:0] c_ST_REQ      = 3'd2;
    localparam logic [2:0] c_ST_BITS     = 3'd3;
    localparam logic [2:0] c_ST_WAITIDLE = 3'd4;
    localparam logic [2:0] c_ST_FIN      = 3'd5;

    // Completion codes reported on err
    localparam logic [1:0] c_ERR_OK    = 2'd0;
    localparam logic [1:0] c_ERR_START = 2'd1;
    localparam logic [1:0] c_ERR_XFER  = 2'd2;
    localparam logic [1:0] c_ERR_NOACK = 2'd3;

    // Timer compare points (the timer starts at 0, so "last" is N-1)
    localparam logic [19:0] c_INH_LAST   = 20'(INHIBIT_CYC - 1);
    localparam logic [19:0] c_INH_PRE    = 20'(INHIBIT_CYC - 2);
    localparam logic [19:0] c_START_LAST = 20'(START_TIMEOUT - 1);
    localparam logic [19:0] c_XFER_LAST  = 20'(XFER_TIMEOUT - 1);
    localparam logic [19:0] c_TIMER_MAX  = 20'hF_FFFF;

    // Falling edge 11 arrives once ten bits have been presented
    localparam logic [3:0]  c_ACK_BITCNT = 4'd10;

    logic        r_clk_s1, r_clk_s2, r_clk_s3;
    logic        r_dat_s1, r_dat_s2;
    logic [2:0]  r_state,   w_state_nxt;
    logic [9:0]  r_frame,   w_frame_nxt;
    logic [3:0]  r_bitcnt,  w_bitcnt_nxt;
    logic [19:0] r_timer,   w_timer_nxt;
    logic        r_clk_oe,  w_clk_oe_nxt;
    logic        r_data_oe, w_data_oe_nxt;
    logic        r_busy,    w_busy_nxt;
    logic        r_done,    w_done_nxt;
    logic [1:0]  r_err,     w_err_nxt;
    logic        w_fe;
    logic        w_fin;
    logic [1:0]  w_fin_err;
    logic [19:0] w_timer_inc;

    // Two-flop synchronisers on both pins, plus one extra clock stage for edge detect.
    // Reset to the idle-high level so leaving reset cannot fake a falling edge.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_clk_s3 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk_in;
            r_clk_s2 <= r_clk_s1;
            r_clk_s3 <= r_clk_s2;
            r_dat_s1 <= ps2_data_in;
            r_dat_s2 <= r_dat_s1;
        end
    end

    assign w_fe        = r_clk_s3 & ~r_clk_s2;
    assign w_timer_inc = (r_timer == c_TIMER_MAX) ? r_timer : r_timer + 20'd1;

    // State register and all registered outputs
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state   <= c_ST_IDLE;
            r_frame   <= '1;
            r_bitcnt  <= '0;
            r_timer   <= '0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= c_ERR_OK;
        end else begin
            r_state   <= w_state_nxt;
            r_frame   <= w_frame_nxt;
            r_bitcnt  <= w_bitcnt_nxt;
            r_timer   <= w_timer_nxt;
            r_clk_oe  <= w_clk_oe_nxt;
            r_data_oe <= w_data_oe_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
        end
    end

    // Next-state and output logic; every way out of a frame funnels through w_fin
    always_comb begin
        w_state_nxt   = r_state;
        w_frame_nxt   = r_frame;
        w_bitcnt_nxt  = r_bitcnt;
        w_timer_nxt   = w_timer_inc;
        w_clk_oe_nxt  = r_clk_oe;
        w_data_oe_nxt = r_data_oe;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_err_nxt     = r_err;
        w_fin         = 1'b0;
        w_fin_err     = c_ERR_OK;

        case (r_state)
            c_ST_IDLE, c_ST_FIN: begin
                w_state_nxt   = c_ST_IDLE;
                w_clk_oe_nxt  = 1'b0;
                w_data_oe_nxt = 1'b0;
                w_busy_nxt    = 1'b0;
                if (wr) begin
                    w_state_nxt  = c_ST_INHIBIT;
                    w_frame_nxt  = {1'b1, ~^din, din};
                    w_bitcnt_nxt = '0;
                    w_timer_nxt  = '0;
                    w_clk_oe_nxt = 1'b1;
                    w_busy_nxt   = 1'b1;
                    w_err_nxt    = c_ERR_OK;
                end
            end

            c_ST_INHIBIT: begin
                if (r_timer == c_INH_LAST) begin
                    // Release the clock with the start bit already on the data line
                    w_state_nxt   = c_ST_REQ;
                    w_clk_oe_nxt  = 1'b0;
                    w_data_oe_nxt = 1'b1;
                    w_timer_nxt   = '0;
                end else if (r_timer == c_INH_PRE) begin
                    w_data_oe_nxt = 1'b1;
                end
            end

            c_ST_REQ: begin
                if (w_fe) begin
                    w_state_nxt   = c_ST_BITS;
                    w_data_oe_nxt = ~r_frame[0];
                    w_frame_nxt   = {1'b1, r_frame[9:1]};
                    w_bitcnt_nxt  = 4'd1;
                    w_timer_nxt   = '0;
                end else if (r_timer == c_START_LAST) begin
                    w_fin     = 1'b1;
                    w_fin_err = c_ERR_START;
                end
            end

            c_ST_BITS: begin
                if (w_fe) begin
                    if (r_bitcnt == c_ACK_BITCNT) begin
                        // Edge 11: device must be holding data low as ack
                        if (!r_dat_s2) begin
                            w_state_nxt = c_ST_WAITIDLE;
                        end else begin
                            w_fin     = 1'b1;
                            w_fin_err = c_ERR_NOACK;
                        end
                    end else begin
                        w_data_oe_nxt = ~r_frame[0];
                        w_frame_nxt   = {1'b1, r_frame[9:1]};
                        w_bitcnt_nxt  = r_bitcnt + 4'd1;
                    end
                end else if (r_timer == c_XFER_LAST) begin
                    w_fin     = 1'b1;
                    w_fin_err = c_ERR_XFER;
                end
            end

            c_ST_WAITIDLE: begin
                if (r_clk_s2 && r_dat_s2) begin
                    w_fin     = 1'b1;
                    w_fin_err = c_ERR_OK;
                end else if (r_timer == c_XFER_LAST) begin
                    w_fin     = 1'b1;
                    w_fin_err = c_ERR_XFER;
                end
            end

            default: begin
                w_state_nxt   = c_ST_IDLE;
                w_clk_oe_nxt  = 1'b0;
                w_data_oe_nxt = 1'b0;
                w_busy_nxt    = 1'b0;
            end
        endcase

        if (w_fin) begin
            w_state_nxt   = c_ST_FIN;
            w_clk_oe_nxt  = 1'b0;
            w_data_oe_nxt = 1'b0;
            w_busy_nxt    = 1'b0;
            w_done_nxt    = 1'b1;
            w_err_nxt     = w_fin_err;
        end
    end

    assign busy        = r_busy;
    assign rx_hold     = r_busy;
    assign done        = r_done;
    assign err         = r_err;
    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;

endmodule
`default_nettype wire
